fifo_burst_reader: RTL

Read-side controller for the 8x32 team FIFO. It drains words through the FIFO's rd_en/empty/data_out/fifo_counter interface and forwards them on a valid/ready stream to a downstream consumer. Reads are grouped into bursts of up to BURST_LEN words, started on a fill threshold or on an idle timeout. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency and downstream backpressure.

---
 rtl/fifo_burst_reader_if.sv | 31 +++
 rtl/fifo_burst_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader_if.sv
// Bundle of the FIFO read port and the downstream valid/ready stream seen by fifo_burst_reader.
// master = the burst reader, slave = the FIFO plus consumer side.
interface fifo_burst_reader_if;
    logic        fifo_empty;
    logic [3:0]  fifo_count;
    logic [31:0] fifo_data;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_count,
        input  fifo_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_count,
        output fifo_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read controller for the 8x32 FIFO with a 2-entry skid buffer on the output stream.
// Optional statistics counters are enabled by defining FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader #(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    fifo_burst_reader_if.master bus,
    output logic                busy,
    output logic                burst_done
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [15:0]         words_out,
    output logic [7:0]          bursts_partial
`endif
);

    localparam logic [3:0] LP_BURST      = 4'(BURST_LEN);
    localparam logic [3:0] LP_BURST_LAST = 4'(BURST_LEN - 1);
    localparam logic [7:0] LP_TO_MAX     = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_burst_cnt;
    logic [7:0]  r_to_cnt;
    logic        r_burst_done;
    logic        r_inflight;
    logic [1:0]  r_occ;
    logic [31:0] r_buf0;
    logic [31:0] r_buf1;

    logic [1:0]  w_pending;
    logic        w_room;
    logic        w_rd_en;
    logic        w_push;
    logic        w_pop;
    logic        w_start_full;
    logic        w_start_to;
    logic        w_drain_empty;

    // Words already in the buffer plus the one possibly in flight bound new reads.
    assign w_pending     = r_occ + {1'b0, r_inflight};
    assign w_room        = (w_pending < 2'd2);
    assign w_rd_en       = (r_state == ST_DRAIN) && !bus.fifo_empty &&
                           (r_burst_cnt < LP_BURST) && w_room;
    assign w_push        = r_inflight;
    assign w_pop         = (r_occ != 2'd0) && bus.m_ready;
    assign w_start_full  = enable && (bus.fifo_count >= LP_BURST);
    assign w_start_to    = enable && !bus.fifo_empty && (r_to_cnt == LP_TO_MAX);
    assign w_drain_empty = (r_state == ST_DRAIN) && bus.fifo_empty && !w_rd_en;

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = (r_occ != 2'd0);
    assign bus.m_data     = r_buf0;
    assign busy           = (r_state != ST_IDLE);
    assign burst_done     = r_burst_done;

    // Burst FSM with burst and idle-timeout counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_burst_cnt  <= 4'd0;
            r_to_cnt     <= 8'd0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_burst_cnt <= 4'd0;
                    if (w_start_full || w_start_to) begin
                        r_state  <= ST_DRAIN;
                        r_to_cnt <= 8'd0;
                    end else if (enable && !bus.fifo_empty) begin
                        if (r_to_cnt != LP_TO_MAX) begin
                            r_to_cnt <= r_to_cnt + 8'd1;
                        end else begin
                            r_to_cnt <= r_to_cnt;
                        end
                    end else begin
                        r_to_cnt <= 8'd0;
                    end
                end
                ST_DRAIN: begin
                    r_to_cnt <= 8'd0;
                    if (w_rd_en) begin
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                    end else begin
                        r_burst_cnt <= r_burst_cnt;
                    end
                    if ((w_rd_en && (r_burst_cnt == LP_BURST_LAST)) ||
                        (r_burst_cnt >= LP_BURST) || w_drain_empty) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_FLUSH: begin
                    r_to_cnt <= 8'd0;
                    if (!r_inflight) begin
                        r_state      <= ST_IDLE;
                        r_burst_done <= 1'b1;
                    end else begin
                        r_state <= ST_FLUSH;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= 4'd0;
                    r_to_cnt    <= 8'd0;
                end
            endcase
        end
    end

    // Skid buffer and in-flight tracking; r_buf0 is always the head word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_buf0     <= 32'd0;
            r_buf1     <= 32'd0;
        end else begin
            r_inflight <= w_rd_en;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= bus.fifo_data;
                    end else begin
                        r_buf1 <= bus.fifo_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= bus.fifo_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= bus.fifo_data;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    logic        r_partial;
    logic [15:0] r_words_out;
    logic [7:0]  r_bursts_partial;

    assign words_out      = r_words_out;
    assign bursts_partial = r_bursts_partial;

    // A burst counts as partial once, whether it started on timeout, ended on empty, or both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_partial        <= 1'b0;
            r_words_out      <= 16'd0;
            r_bursts_partial <= 8'd0;
        end else begin
            if (w_pop) begin
                r_words_out <= r_words_out + 16'd1;
            end else begin
                r_words_out <= r_words_out;
            end
            if ((r_state == ST_IDLE) && w_start_to && !w_start_full) begin
                r_partial <= 1'b1;
            end else if (w_drain_empty) begin
                r_partial <= 1'b1;
            end else if ((r_state == ST_FLUSH) && !r_inflight) begin
                r_partial <= 1'b0;
                if (r_partial && (r_bursts_partial != 8'hFF)) begin
                    r_bursts_partial <= r_bursts_partial + 8'd1;
                end else begin
                    r_bursts_partial <= r_bursts_partial;
                end
            end else begin
                r_partial <= r_partial;
            end
        end
    end
`endif

endmodule
